// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Handshaked memory-access sequencer between the core datapath and
//            the native memory bus. Generates byte strobes and lane-rotated
//            store data, sign/zero-extends loads, and splits accesses that
//            cross a bus-word boundary into two beats (or flags misaligned
//            accesses as errors when they are not allowed).
// Ports    : clk, reset          - clock, synchronous active-high reset
//            req_*               - core request (valid/ready, we, size,
//                                  unsigned, addr, wdata)
//            rsp_*               - one-cycle completion (valid, rdata, err)
//            mem_*               - memory bus (valid/ready, addr, wstrb,
//                                  wdata, rdata)
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int XLEN             = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [31:0]       mem_addr,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]       r_addr;
  logic [1:0]        r_size;
  logic              r_we;
  logic              r_uns;
  logic              r_err;
  logic [XLEN-1:0]   r_wdata;
  logic [2*XLEN-1:0] r_buf;

  // --------------------------------------------------------------------------
  // Request decode (evaluated on the raw request while idle)
  // --------------------------------------------------------------------------
  logic w_req_mis;
  logic w_req_illegal;
  logic w_req_err;

  always_comb begin
    case (req_size)
      2'd0:    w_req_mis = 1'b0;
      2'd1:    w_req_mis = req_addr[0];
      2'd2:    w_req_mis = |req_addr[1:0];
      default: w_req_mis = |req_addr[2:0];
    endcase
    w_req_illegal = (req_size == 2'd3) && (XLEN == 32);
    w_req_err     = w_req_illegal || (w_req_mis && (ALLOW_MISALIGNED == 0));
  end

  // --------------------------------------------------------------------------
  // Datapath derived from the latched request
  // --------------------------------------------------------------------------
  logic [OFFW-1:0]   w_off;
  logic [OFFW+2:0]   w_shamt;
  logic [3:0]        w_bytes;
  logic [4:0]        w_end;
  logic              w_cross;
  logic [2*NB-1:0]   w_lenmask;
  logic [2*NB-1:0]   w_mask;
  logic [2*XLEN-1:0] w_dbl;
  logic [XLEN-1:0]   w_rot;
  logic [31:0]       w_base;
  logic [2*XLEN-1:0] w_buf_sh;
  logic              w_fill;
  logic [XLEN-1:0]   w_ext;

  always_comb begin
    w_off   = r_addr[OFFW-1:0];
    w_shamt = {w_off, 3'b000};
    w_bytes = 4'd1 << r_size;
    w_end   = 5'(w_off) + 5'(w_bytes);
    w_cross = w_end > 5'(NB);

    // Byte-enable mask spanning two bus words; the upper half feeds beat 1.
    for (int i = 0; i < 2*NB; i++) begin
      w_lenmask[i] = (i < int'(w_bytes));
    end
    w_mask = w_lenmask << w_off;

    // Rotation keeps every byte of the store on the lane it lands in, so both
    // beats can drive the same data word.
    w_dbl  = {r_wdata, r_wdata} << w_shamt;
    w_rot  = w_dbl[2*XLEN-1:XLEN];
    w_base = {r_addr[31:OFFW], {OFFW{1'b0}}};

    // Load extraction: shift the two-beat buffer down, keep 'bytes' bytes,
    // then extend from the top kept bit.
    w_buf_sh = r_buf >> w_shamt;
    case (r_size)
      2'd0:    w_fill = ~r_uns & w_buf_sh[7];
      2'd1:    w_fill = ~r_uns & w_buf_sh[15];
      2'd2:    w_fill = ~r_uns & w_buf_sh[31];
      default: w_fill = ~r_uns & w_buf_sh[63];
    endcase
    for (int i = 0; i < XLEN; i++) begin
      w_ext[i] = (i < int'(w_bytes) * 8) ? w_buf_sh[i] : w_fill;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;

    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = w_req_err ? S_RESP : S_BEAT0;
        end
      end
      S_BEAT0: begin
        mem_valid = 1'b1;
        mem_addr  = w_base;
        mem_wstrb = r_we ? w_mask[NB-1:0] : '0;
        mem_wdata = r_we ? w_rot : '0;
        if (mem_ready) begin
          w_next = w_cross ? S_BEAT1 : S_RESP;
        end
      end
      S_BEAT1: begin
        mem_valid = 1'b1;
        mem_addr  = w_base + 32'(NB);
        mem_wstrb = r_we ? w_mask[2*NB-1:NB] : '0;
        mem_wdata = r_we ? w_rot : '0;
        if (mem_ready) begin
          w_next = S_RESP;
        end
      end
      default: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        rsp_rdata = (r_we || r_err) ? '0 : w_ext;
        w_next    = S_IDLE;
      end
    endcase

    // Outputs are forced quiet for the whole reset interval, including the
    // first reset cycle when the state register has not yet returned to idle.
    if (reset) begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      rsp_err   = 1'b0;
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_wstrb = '0;
      mem_wdata = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Request latch and read buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= '0;
      r_size  <= '0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= '0;
      r_buf   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_size  <= req_size;
            r_we    <= req_we;
            r_uns   <= req_unsigned;
            r_err   <= w_req_err;
            r_wdata <= req_wdata;
            r_buf   <= '0;
          end
        end
        S_BEAT0: begin
          if (mem_ready) begin
            r_buf[XLEN-1:0] <= mem_rdata;
          end
        end
        S_BEAT1: begin
          if (mem_ready) begin
            r_buf[2*XLEN-1:XLEN] <= mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
